// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared ALU opcodes, Z-stage FSM encoding and op classification helper
package cpu_alu_pkg;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHRA = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_ROR  = 5'd10;
   localparam logic [4:0] OP_ROL  = 5'd11;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
   function automatic logic is_multi(input logic [4:0] op);
      return op == OP_MUL || op == OP_DIV;
   endfunction
endpackage

// File: rtl/z_bus_mux.sv
// z_bus_mux: drives one half of Z onto the internal bus; low half has priority, idle bus reads 0
module z_bus_mux (
   input  logic [63:0] z,
   input  logic        zhigh_out,
   input  logic        zlow_out,
   output logic [31:0] bus_out
);
   assign bus_out = zlow_out ? z[31:0] : zhigh_out ? z[63:32] : 32'h0;
endmodule

// File: rtl/alu_z_stage.sv
// alu_z_stage: captures ALU results into the 64-bit Z register, runs the MUL/DIV
// start/done handshake with timeout, and drives Z halves onto the bus with flags.
module alu_z_stage
   import cpu_alu_pkg::*;
#(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 7
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic        zin,
   input  logic [4:0]  op_sel,
   input  logic [31:0] alu_lo,
   input  logic [63:0] mc_result,
   input  logic        mc_done,
   output logic        mc_start,
   output logic        mc_abort,
   input  logic        zhigh_out,
   input  logic        zlow_out,
   output logic [31:0] bus_out,
   output logic        z_valid,
   output logic        busy,
   output logic        flag_zero,
   output logic        flag_neg,
   output logic        err
);
   state_t           state, state_nx;
   logic [63:0]      z;
   logic [CNT_W-1:0] cnt;
   logic             done_hit, time_hit;
   always_comb begin
      done_hit = state == WAIT && mc_done;
      time_hit = state == WAIT && !mc_done && cnt == CNT_W'(MC_TIMEOUT - 1);
      state_nx = state == IDLE  ? (zin && is_multi(op_sel) ? START : IDLE)
               : state == START ? WAIT
               : done_hit || time_hit ? IDLE : WAIT;
   end
   assign mc_start  = state == START;
   assign mc_abort  = time_hit;
   assign busy      = state != IDLE;
   assign flag_zero = z[31:0] == 32'h0;
   assign flag_neg  = z[31];
   always_ff @(posedge clock or negedge clear_n)
      if (!clear_n) begin
         state   <= IDLE;
         z       <= '0;
         cnt     <= '0;
         z_valid <= 1'b0;
         err     <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= state == WAIT ? cnt + 1'b1 : '0;
         if (state == IDLE && zin) begin
            z_valid <= !is_multi(op_sel);
            err     <= 1'b0;
            if (!is_multi(op_sel)) z <= {32'h0, alu_lo};
         end else if (done_hit) begin
            z       <= mc_result;
            z_valid <= 1'b1;
         end else if (time_hit) begin
            z       <= '0;
            z_valid <= 1'b1;
            err     <= 1'b1;
         end
      end
   z_bus_mux u_mux (
      .z         (z),
      .zhigh_out (zhigh_out),
      .zlow_out  (zlow_out),
      .bus_out   (bus_out)
   );
endmodule

// File: tb/tb_alu_z_stage.sv
// tb_alu_z_stage: directed bench with a cycle-timestamp reference model checked every
// negedge, plus literal expectations for the capture, handshake, timeout and reset scenarios.
module tb_alu_z_stage;
   import cpu_alu_pkg::*;
   localparam int TO = 64;
   logic        clock = 1'b0, clear_n = 1'b1, zin = 1'b0, mc_done = 1'b0;
   logic        zhigh_out = 1'b0, zlow_out = 1'b1;
   logic [4:0]  op_sel = 5'd0;
   logic [31:0] alu_lo = 32'h0, bus_out;
   logic [63:0] mc_result = 64'h0;
   logic        mc_start, mc_abort, z_valid, busy, flag_zero, flag_neg, err;
   int          n_chk = 0, n_fail = 0;
   bit          run = 1'b0;

   alu_z_stage #(.MC_TIMEOUT(TO), .CNT_W(7)) dut (
      .clock(clock), .clear_n(clear_n), .zin(zin), .op_sel(op_sel), .alu_lo(alu_lo),
      .mc_result(mc_result), .mc_done(mc_done), .mc_start(mc_start), .mc_abort(mc_abort),
      .zhigh_out(zhigh_out), .zlow_out(zlow_out), .bus_out(bus_out), .z_valid(z_valid),
      .busy(busy), .flag_zero(flag_zero), .flag_neg(flag_neg), .err(err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: timestamps cycles; an accepted multi-cycle op at edge index e0-1 makes
   // cycle e0 the start cycle and cycles e0+1..e0+TO the waiting window.
   logic [63:0] m_z = '0;
   bit          m_valid = 0, m_err = 0, m_fly = 0;
   int          e = 0, e0 = 0;
   always @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         m_z = '0; m_valid = 0; m_err = 0; m_fly = 0;
      end else begin
         if (m_fly && e >= e0 + 1) begin
            if (mc_done) begin
               m_z = mc_result; m_valid = 1; m_fly = 0;
            end else if (e == e0 + TO) begin
               m_z = '0; m_valid = 1; m_err = 1; m_fly = 0;
            end
         end else if (!m_fly && zin) begin
            m_err = 0;
            if (op_sel == OP_MUL || op_sel == OP_DIV) begin
               m_fly = 1; e0 = e + 1; m_valid = 0;
            end else begin
               m_z = {32'h0, alu_lo}; m_valid = 1;
            end
         end
      end
      if (clear_n) e++;
   end

   always @(negedge clock) if (run) begin
      chk("m_bus", {32'h0, bus_out},
          {32'h0, zlow_out ? m_z[31:0] : zhigh_out ? m_z[63:32] : 32'h0});
      chk("m_valid", {63'h0, z_valid}, {63'h0, m_valid});
      chk("m_busy", {63'h0, busy}, {63'h0, m_fly});
      chk("m_zero", {63'h0, flag_zero}, {63'h0, m_z[31:0] == 32'h0});
      chk("m_neg", {63'h0, flag_neg}, {63'h0, m_z[31]});
      chk("m_err", {63'h0, err}, {63'h0, m_err});
      chk("m_start", {63'h0, mc_start}, {63'h0, m_fly && e == e0});
      chk("m_abort", {63'h0, mc_abort}, {63'h0, m_fly && e == e0 + TO && !mc_done});
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1 clear_n = 1'b0;
      #1;
      chk("rst_valid", {63'h0, z_valid}, 64'h0);
      chk("rst_zero", {63'h0, flag_zero}, 64'h1);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      run = 1'b1;
      step(); step();
      clear_n = 1'b1;
      step();
      // ROL capture
      zin = 1'b1; op_sel = OP_ROL; alu_lo = 32'h0000_0003;
      step();
      zin = 1'b0;
      chk("rol_bus", {32'h0, bus_out}, 64'h3);
      chk("rol_valid", {63'h0, z_valid}, 64'h1);
      chk("rol_flags", {62'h0, flag_zero, flag_neg}, 64'h0);
      zlow_out = 1'b0; zhigh_out = 1'b1; #1;
      chk("rol_high", {32'h0, bus_out}, 64'h0);
      // MUL handshake, done after 32 cycles
      zin = 1'b1; op_sel = OP_MUL;
      step();
      zin = 1'b0;
      chk("mul_start", {62'h0, mc_start, busy}, 64'h3);
      chk("mul_valid", {63'h0, z_valid}, 64'h0);
      step();
      chk("mul_start_off", {63'h0, mc_start}, 64'h0);
      repeat (30) step();
      mc_done = 1'b1; mc_result = 64'h0000_0001_FFFF_FFFE;
      step();
      mc_done = 1'b0;
      chk("mul_high", {32'h0, bus_out}, 64'h1);
      chk("mul_neg_busy", {62'h0, flag_neg, busy}, 64'h2);
      // bus priority / idle
      zlow_out = 1'b1; #1;
      chk("both_en", {32'h0, bus_out}, 64'hFFFF_FFFE);
      zlow_out = 1'b0; zhigh_out = 1'b0; #1;
      chk("no_en", {32'h0, bus_out}, 64'h0);
      zlow_out = 1'b1;
      // DIV timeout
      zin = 1'b1; op_sel = OP_DIV;
      step();
      zin = 1'b0;
      repeat (TO - 1) step();
      chk("to_pre", {63'h0, mc_abort}, 64'h0);
      step();
      chk("to_abort", {62'h0, mc_abort, busy}, 64'h3);
      step();
      chk("to_err", {60'h0, err, z_valid, flag_zero, mc_abort}, 64'hE);
      chk("to_bus", {32'h0, bus_out}, 64'h0);
      zin = 1'b1; op_sel = OP_AND; alu_lo = 32'h0;
      step();
      zin = 1'b0;
      chk("err_clear", {62'h0, err, flag_zero}, 64'h1);
      // busy rejection
      zin = 1'b1; op_sel = OP_MUL;
      step(); step();
      op_sel = OP_ADD; alu_lo = 32'h5;
      step();
      zin = 1'b0;
      chk("rej_busy", {63'h0, busy}, 64'h1);
      repeat (4) step();
      mc_done = 1'b1; mc_result = 64'hDEAD_BEEF_0000_1234;
      step();
      mc_done = 1'b0;
      chk("rej_lo", {32'h0, bus_out}, 64'h1234);
      zlow_out = 1'b0; zhigh_out = 1'b1; #1;
      chk("rej_hi", {32'h0, bus_out}, 64'hDEAD_BEEF);
      zlow_out = 1'b1; zhigh_out = 1'b0;
      // async reset mid-WAIT
      zin = 1'b1; op_sel = OP_DIV;
      step();
      zin = 1'b0;
      repeat (5) step();
      clear_n = 1'b0; #1;
      chk("ar_outs", {58'h0, busy, z_valid, mc_start, mc_abort, err, flag_zero}, 64'h1);
      chk("ar_bus", {32'h0, bus_out}, 64'h0);
      step();
      clear_n = 1'b1;
      mc_done = 1'b1; mc_result = 64'h1234_5678_9ABC_DEF0;
      step();
      mc_done = 1'b0;
      chk("ar_ignore", {62'h0, z_valid, busy}, 64'h0);
      chk("ar_bus2", {32'h0, bus_out}, 64'h0);
      step(); step();
      run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
